// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory: access-size encodings,
// controller states, the latched-request record and the access check.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_RSV = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Everything the response phase needs to know about the accepted request.
  typedef struct packed {
    logic       write;
    size_e      size;
    logic       unsgn;
    logic [1:0] lane;
    logic       err;
  } req_t;

  // Flags reserved sizes, misaligned halfwords/words and addresses beyond
  // the end of a memory of 'depth' 32-bit words.
  function automatic logic access_error(input size_e size,
                                        input logic [31:0] addr,
                                        input int depth);
    logic [31:0] limit;
    limit = 32'(depth) << 2;
    return (size == SIZE_RSV) ||
           ((size == SIZE_H) && addr[0]) ||
           ((size == SIZE_W) && (addr[1:0] != 2'b00)) ||
           (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit memory word and right-aligned
// core data. Store side builds the lane mask and replicated write word;
// load side picks the addressed lane(s) and sign/zero extends.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  input  size_e       ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign rd_byte[gi] = ld_word[gi*8 +: 8];
    end
  endgenerate

  // Store path: replicate the data across the word so any lane can take it,
  // and enable only the lanes the access covers.
  always_comb begin
    st_be   = 4'b0000;
    st_word = 32'd0;
    case (st_size)
      SIZE_B: begin
        st_be   = 4'b0001 << st_lane;
        st_word = {4{st_wdata[7:0]}};
      end
      SIZE_H: begin
        st_be   = st_lane[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_wdata[15:0]}};
      end
      SIZE_W: begin
        st_be   = 4'b1111;
        st_word = st_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_word = 32'd0;
      end
    endcase
  end

  // Load path: select the addressed byte/half, then extend to 32 bits.
  always_comb begin
    sel_byte = rd_byte[ld_lane];
    sel_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data  = 32'd0;
    case (ld_size)
      SIZE_B:  ld_data = {{24{~ld_unsigned & sel_byte[7]}}, sel_byte};
      SIZE_H:  ld_data = {{16{~ld_unsigned & sel_half[15]}}, sel_half};
      SIZE_W:  ld_data = ld_word;
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Single-port byte/half/word data memory with a one-outstanding-request
// valid/ready handshake and a fixed, parameterised response latency.
// Stores commit and loads read on the accept edge; the response is then
// delayed by the latency counter and held until the consumer takes it.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_q;

  logic             accept;
  logic             acc_err;
  logic             wr_en;
  logic             rd_en;
  logic [IDX_W-1:0] idx;
  logic [3:0]       st_be;
  logic [31:0]      st_word;
  logic [31:0]      ld_data;

  assign accept  = (state_q == IDLE) && req_valid;
  assign acc_err = access_error(size_e'(req_size), req_addr, DEPTH_WORDS);
  assign idx     = req_addr[IDX_W+1:2];
  assign wr_en   = accept && req_write && !acc_err;
  assign rd_en   = accept && !req_write && !acc_err;

  dmem_lane_align u_align (
    .st_size     (size_e'(req_size)),
    .st_lane     (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_be       (st_be),
    .st_word     (st_word),
    .ld_size     (req_q.size),
    .ld_lane     (req_q.lane),
    .ld_unsigned (req_q.unsgn),
    .ld_word     (rd_word_q),
    .ld_data     (ld_data)
  );

  // Memory array: lane-masked write and registered read, both on accept.
  // No reset here so the array maps onto block RAM and keeps its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[idx][b*8 +: 8] <= st_word[b*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_word_q <= mem[idx];
    end
  end

  // Next-state logic. The counter holds the edges still to wait; WAIT is
  // left on the edge that brings it to zero so resp_valid is seen at the
  // LATENCY-th edge after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.size  = size_e'(req_size);
          req_d.unsgn = req_unsigned;
          req_d.lane  = req_addr[1:0];
          req_d.err   = acc_err;
          cnt_d       = CNT_LOAD;
          state_d     = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Responses only carry data for good loads; stores and errors return 0.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_error = (state_q == RESP) && req_q.err;
  assign resp_rdata = ((state_q == RESP) && !req_q.write && !req_q.err) ? ld_data : 32'd0;

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: three instances (latency 1, 3, 4), a table of
// directed vectors, backpressure and reset sequences, then random traffic
// against a byte-addressed reference model.
module tb_sized_data_memory;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n        [NDUT];
  logic        req_valid    [NDUT];
  logic        req_ready    [NDUT];
  logic        req_write    [NDUT];
  logic [1:0]  req_size     [NDUT];
  logic        req_unsigned [NDUT];
  logic [31:0] req_addr     [NDUT];
  logic [31:0] req_wdata    [NDUT];
  logic        resp_valid   [NDUT];
  logic        resp_ready   [NDUT];
  logic [31:0] resp_rdata   [NDUT];
  logic        resp_error   [NDUT];

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] mem_m [NDUT][NBYTE];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      sized_data_memory #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n[gi]),
        .req_valid    (req_valid[gi]),
        .req_ready    (req_ready[gi]),
        .req_write    (req_write[gi]),
        .req_size     (req_size[gi]),
        .req_unsigned (req_unsigned[gi]),
        .req_addr     (req_addr[gi]),
        .req_wdata    (req_wdata[gi]),
        .resp_valid   (resp_valid[gi]),
        .resp_ready   (resp_ready[gi]),
        .resp_rdata   (resp_rdata[gi]),
        .resp_error   (resp_error[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain byte array, accesses as runs of bytes.
  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
           (size == 2'd2 && (addr % 4) != 0) || (addr >= 32'(NBYTE));
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [1:0] size,
                                         input logic uns, input logic [31:0] addr);
    int nb;
    logic [31:0] v;
    nb = 1 << size;
    v  = 32'd0;
    for (int i = 0; i < nb; i++) v = v | (32'(mem_m[d][int'(addr) + i]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input int d, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) mem_m[d][int'(addr) + i] = wdata[8*i +: 8];
  endtask

  // One full request/response, starting and ending at posedge+1.
  task automatic txn(input int d, input logic wr, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                     output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_req", 32'(req_ready[d]), 32'd1);
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    resp_ready[d]   = (stall == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    if (wr && !m_err(size, addr)) m_store(d, size, addr, wdata);
    n = 1;
    while (!resp_valid[d] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(lat_of(d)));
    rdata = resp_rdata[d];
    err   = resp_error[d];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(resp_valid[d]), 32'd1);
      chk("stall_rdata", resp_rdata[d], rdata);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    chk("hs_ready", 32'(req_ready[d]), 32'd1);
    chk("hs_valid_low", 32'(resp_valid[d]), 32'd0);
    $display("txn dut%0d %s size=%0d uns=%0b addr=%08h wdata=%08h -> rdata=%08h err=%0b",
             d, wr ? "st" : "ld", size, uns, addr, wdata, rdata, err);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_d;
    logic        exp_e;
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    int          n;
    int          seen;

    for (int d = 0; d < NDUT; d++) begin
      for (int b = 0; b < NBYTE; b++) mem_m[d][b] = 8'h00;
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0; resp_ready[d] = 1'b1;
    end

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h20,  32'h80FF7F01, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h22,  32'h0,        32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h23,  32'h0,        32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h20,  32'h0,        32'h00007F01, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'hFFFF80FF, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        32'h000080FF, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h30,  32'h11223344, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h31,  32'h000000AA, 32'h00000000, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h32,  32'h0000BEEF, 32'h00000000, 1'b0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h30,  32'h0,        32'hBEEFAA44, 1'b0};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h04,  32'h01234567, 32'h00000000, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h08,  32'h89ABCDEF, 32'h00000000, 1'b0};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h00,  32'hCAFEF00D, 32'h00000000, 1'b0};
    tbl[15] = '{1'b1, 2'd1, 1'b0, 32'h05,  32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[16] = '{1'b1, 2'd2, 1'b0, 32'h06,  32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[17] = '{1'b1, 2'd3, 1'b0, 32'h08,  32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[18] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h04,  32'h0,        32'h01234567, 1'b0};
    tbl[20] = '{1'b0, 2'd2, 1'b0, 32'h08,  32'h0,        32'h89ABCDEF, 1'b0};
    tbl[21] = '{1'b0, 2'd2, 1'b0, 32'h00,  32'h0,        32'hCAFEF00D, 1'b0};
    tbl[22] = '{1'b0, 2'd1, 1'b1, 32'h21,  32'h0,        32'h00000000, 1'b1};
    tbl[23] = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,   32'h00000000, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[d], 32'd0);
      chk("rst_resp_error", 32'(resp_error[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;

    // Give every instance known (zero) contents
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < DEPTH; w++)
        txn(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'd0, 0, rd, er);

    // Directed table on the latency-1 instance
    for (int i = 0; i < 24; i++) begin
      txn(0, tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 0, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_error", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Backpressure on the latency-3 instance
    txn(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5AA5A5, 0, rd, er);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'h40; resp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_write[1] = 1'b1; req_wdata[1] = 32'h0;
    n = 1;
    while (!resp_valid[1] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", 32'(n), 32'd3);
    chk("bp_rdata", resp_rdata[1], 32'h5A5AA5A5);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(resp_valid[1]), 32'd1);
      chk("bp_hold_rdata", resp_rdata[1], 32'h5A5AA5A5);
      chk("bp_hold_error", 32'(resp_error[1]), 32'd0);
      chk("bp_hold_ready", 32'(req_ready[1]), 32'd0);
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_ready", 32'(req_ready[1]), 32'd1);
    chk("bp_after_hs_valid", 32'(resp_valid[1]), 32'd0);
    $display("txn dut1 ld backpressured addr=00000040");
    txn(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, rd, er);
    chk("bp_ignored_store", rd, 32'h5A5AA5A5);

    // Reset while a store's response is pending (latency-4 instance)
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_size[2] = 2'd2;
    req_addr[2] = 32'h48; req_wdata[2] = 32'h0BADCAFE;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    m_store(2, 2'd2, 32'h48, 32'h0BADCAFE);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    chk("rst_st_valid", 32'(resp_valid[2]), 32'd0);
    chk("rst_st_ready", 32'(req_ready[2]), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    $display("txn dut2 st addr=00000048 interrupted by reset");

    // Reset while a load is in flight
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h48;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    seen = 0;
    @(posedge clk); #1;
    if (resp_valid[2]) seen++;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    chk("rst_ld_valid", 32'(resp_valid[2]), 32'd0);
    chk("rst_ld_ready", 32'(req_ready[2]), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_valid[2]) seen++;
    end
    chk("rst_ld_no_resp", 32'(seen), 32'd0);
    chk("rst_ld_ready_after", 32'(req_ready[2]), 32'd1);
    $display("txn dut2 ld addr=00000048 dropped by reset");
    txn(2, 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 0, rd, er);
    chk("rst_store_committed", rd, 32'h0BADCAFE);

    // Random traffic against the model
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 50; k++) begin
        wr = 1'($urandom_range(0, 1));
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        un = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) ad = 32'(NBYTE) + 32'($urandom_range(0, 4095));
        else begin
          ad = 32'($urandom_range(0, NBYTE - 1));
          if ($urandom_range(0, 4) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
        end
        exp_e = m_err(sz, ad);
        exp_d = (wr || exp_e) ? 32'd0 : m_load(d, sz, un, ad);
        txn(d, wr, sz, un, ad, $urandom, int'($urandom_range(0, 2)), rd, er);
        chk("rand_rdata", rd, exp_d);
        chk("rand_error", 32'(er), 32'(exp_e));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
